// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight writers resolving ID-stage
// operand forwarding and stalls. Define HAZARD_FWD_EN to forward from the slots.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 32,
  parameter int LOAD_READY = 2,
  parameter int MUL_READY  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [4:0]                   id_rs_addr,
  input  logic [4:0]                   id_rt_addr,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic                         id_we,
  input  logic [4:0]                   id_waddr,
  input  logic [1:0]                   id_class,
  input  logic                         pipe_hold,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0]            rs_data_in,
  input  logic [DATA_W-1:0]            rt_data_in,
  output logic [DATA_W-1:0]            rs_data,
  output logic [DATA_W-1:0]            rt_data,
  output logic                         stall,
  output logic [31:0]                  stall_count
);
  localparam int RW = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic              hazard;
    logic [DATA_W-1:0] data;
  } src_res_t;

  logic [NUM_STAGES:1]         valid_q, valid_d;
  logic [NUM_STAGES:1][4:0]    waddr_q, waddr_d;
  logic [NUM_STAGES:1][RW-1:0] ready_q, ready_d;
  logic [31:0]                 count_q, count_d;
  logic                        issue_s, new_valid_s;
  logic [RW-1:0]               new_ready_s;
  src_res_t                    rs_res_s, rt_res_s;

`ifdef HAZARD_FWD_EN
  logic [DATA_W-1:0] slot_data_s [1:NUM_STAGES];

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_slot
    assign slot_data_s[k] = stage_data[k*DATA_W-1 -: DATA_W];
  end
`else
  logic unused_stage_data_s;
  assign unused_stage_data_s = ^stage_data;
`endif

  // The youngest (lowest-slot) valid writer of addr decides forward vs. hazard.
  function automatic src_res_t resolve(input logic [4:0] addr, input logic used,
                                       input logic [DATA_W-1:0] rf_data);
    src_res_t res;
    logic     hit;
    logic     match;
`ifdef HAZARD_FWD_EN
    logic [RW-1:0] slot;
    slot = {RW{1'b0}};
`endif
    res.hazard = 1'b0;
    res.data   = rf_data;
    hit        = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      match = valid_q[k] && (waddr_q[k] == addr) && (addr != 5'd0);
      hit   = hit | match;
`ifdef HAZARD_FWD_EN
      slot  = match ? RW'(k) : slot;
`endif
    end
    if (hit) begin
`ifdef HAZARD_FWD_EN
      if (slot >= ready_q[slot]) begin
        res.data = slot_data_s[slot];
      end else begin
        res.hazard = used;
      end
`else
      res.hazard = used;
`endif
    end else begin
      res.hazard = 1'b0;
    end
    return res;
  endfunction

  // Operand resolution against the current slots, no added latency.
  always_comb begin
    rs_res_s = resolve(id_rs_addr, id_rs_used, rs_data_in);
    rt_res_s = resolve(id_rt_addr, id_rt_used, rt_data_in);
  end

  assign rs_data     = rs_res_s.data;
  assign rt_data     = rt_res_s.data;
  assign stall       = id_valid & (rs_res_s.hazard | rt_res_s.hazard);
  assign issue_s     = id_valid & ~stall & ~pipe_hold;
  assign new_valid_s = issue_s & id_we & (id_waddr != 5'd0) & (id_class != 2'b11);
  assign stall_count = count_q;

  // Result class selects the first slot at which the value is forwardable.
  always_comb begin
    case (id_class)
      2'b00:   new_ready_s = RW'(32'd1);
      2'b01:   new_ready_s = RW'(LOAD_READY);
      2'b10:   new_ready_s = RW'(MUL_READY);
      default: new_ready_s = RW'(NUM_STAGES);
    endcase
  end

  // Slots advance one stage per unfrozen cycle; a stall feeds a bubble into slot 1.
  always_comb begin
    if (pipe_hold) begin
      valid_d = valid_q;
      waddr_d = waddr_q;
      ready_d = ready_q;
      count_d = count_q;
    end else begin
      valid_d = {valid_q[NUM_STAGES-1:1], new_valid_s};
      waddr_d = {waddr_q[NUM_STAGES-1:1], id_waddr};
      ready_d = {ready_q[NUM_STAGES-1:1], new_ready_s};
      count_d = stall ? (count_q + 32'd1) : count_q;
    end
  end

  // Scoreboard and stall counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {NUM_STAGES{1'b0}};
      waddr_q <= {(NUM_STAGES*5){1'b0}};
      ready_q <= {(NUM_STAGES*RW){1'b0}};
      count_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios checked every cycle against a queue-based
// model of in-flight producers, plus literal expectations per scenario.
module tb_hazard_scoreboard;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int LR = 2;
  localparam int MR = 3;

  localparam logic [31:0] RF_RS = 32'h1111_1111;
  localparam logic [31:0] RF_RT = 32'h2222_2222;

`ifdef HAZARD_FWD_EN
  localparam int L_ALU = 0, L_LD = 1, L_MUL = 2, L_YNG = 0;
  localparam logic [31:0] D_ALU = 32'h0000_1234, D_LD = 32'h3333_0002;
  localparam logic [31:0] D_MUL = 32'h3333_0003, D_YNG = 32'h0000_000A;
  localparam logic [31:0] C_ALU = 32'd0, C_LD = 32'd1, C_MUL = 32'd3, C_END = 32'd3;
`else
  localparam int L_ALU = 3, L_LD = 3, L_MUL = 3, L_YNG = 3;
  localparam logic [31:0] D_ALU = RF_RS, D_LD = RF_RT, D_MUL = RF_RS, D_YNG = RF_RS;
  localparam logic [31:0] C_ALU = 32'd3, C_LD = 32'd6, C_MUL = 32'd9, C_END = 32'd12;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [4:0]        id_rs_addr = 5'd0, id_rt_addr = 5'd0, id_waddr = 5'd0;
  logic              id_rs_used = 1'b0, id_rt_used = 1'b0, id_we = 1'b0;
  logic [1:0]        id_class = 2'b11;
  logic              pipe_hold = 1'b0;
  logic [NS*DW-1:0]  stage_data = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
  logic [DW-1:0]     rs_data_in = RF_RS, rt_data_in = RF_RT;
  logic [DW-1:0]     rs_data, rt_data;
  logic              stall;
  logic [31:0]       stall_count;

  hazard_scoreboard #(.NUM_STAGES(NS), .DATA_W(DW), .LOAD_READY(LR), .MUL_READY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_we(id_we), .id_waddr(id_waddr), .id_class(id_class),
    .pipe_hold(pipe_hold), .stage_data(stage_data),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .stall_count(stall_count)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: list of in-flight producers, each knowing how many stages it has travelled.
  typedef struct {
    logic [4:0] waddr;
    int         ready;
    int         pos;
  } prod_t;

  prod_t       mq[$];
  logic [31:0] m_count = 32'd0;

  function automatic logic [31:0] slot_val(input int k);
    return stage_data[k*DW-1 -: DW];
  endfunction

  function automatic void model_src(input logic [4:0] a, input logic used, input logic [31:0] rf,
                                    output logic haz, output logic [31:0] d);
    int best = 0;
    int rdy  = 0;
    haz = 1'b0;
    d   = rf;
    foreach (mq[i]) begin
      if (a != 5'd0 && mq[i].waddr == a && (best == 0 || mq[i].pos < best)) begin
        best = mq[i].pos;
        rdy  = mq[i].ready;
      end
    end
    if (best != 0) begin
`ifdef HAZARD_FWD_EN
      if (best >= rdy) d = slot_val(best);
      else haz = used;
`else
      haz = used | (rdy < 0);
`endif
    end
  endfunction

  function automatic logic model_stall();
    logic h1, h2;
    logic [31:0] d1, d2;
    model_src(id_rs_addr, id_rs_used, rs_data_in, h1, d1);
    model_src(id_rt_addr, id_rt_used, rt_data_in, h2, d2);
    return id_valid & (h1 | h2);
  endfunction

  function automatic int class_ready(input logic [1:0] c);
    if (c == 2'b01) return LR;
    if (c == 2'b10) return MR;
    return 1;
  endfunction

  // Model state update
  initial forever begin
    logic st;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_count = 32'd0;
    end else if (!pipe_hold) begin
      st = model_stall();
      if (st) m_count = m_count + 32'd1;
      foreach (mq[i]) mq[i].pos = mq[i].pos + 1;
      while (mq.size() > 0 && mq[0].pos > NS) void'(mq.pop_front());
      if (id_valid && !st && id_we && id_waddr != 5'd0 && id_class != 2'b11)
        mq.push_back('{waddr: id_waddr, ready: class_ready(id_class), pos: 1});
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    logic h_rs, h_rt;
    logic [31:0] e_rs, e_rt;
    @(negedge clk);
    model_src(id_rs_addr, id_rs_used, rs_data_in, h_rs, e_rs);
    model_src(id_rt_addr, id_rt_used, rt_data_in, h_rt, e_rt);
    check("cyc_stall", {31'd0, stall}, {31'd0, id_valid & (h_rs | h_rt)});
    check("cyc_rs_data", rs_data, e_rs);
    check("cyc_rt_data", rt_data, e_rt);
    check("cyc_stall_count", stall_count, m_count);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic we, input logic [4:0] wa, input logic [1:0] cls);
    id_valid = v; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
    id_we = we; id_waddr = wa; id_class = cls;
  endtask

  task automatic drain();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b11);
    stage_data = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    repeat (NS + 1) step();
  endtask

  task automatic expect_stalls(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      #3;
      check(nm, {31'd0, stall}, 32'd1);
      step();
    end
    #3;
    check(nm, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    repeat (2) step();
    #3;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_count", stall_count, 32'd0);
    check("reset_rs", rs_data, RF_RS);
    rst_n = 1'b1;
    step();

    // ALU -> back-to-back reader of $3
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'b00);
    step();
    stage_data = {32'h3333_0003, 32'h3333_0002, 32'h0000_1234};
    instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    expect_stalls(L_ALU, "alu_stall");
    check("alu_rs_data", rs_data, D_ALU);
    step();
    drain();
    check("alu_count", stall_count, C_ALU);

    // Load-use on rt
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b01);
    step();
    instr(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'b00);
    expect_stalls(L_LD, "load_stall");
    check("load_rt_data", rt_data, D_LD);
    step();
    drain();
    check("load_count", stall_count, C_LD);

    // MUL dependency on rs
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'b10);
    step();
    instr(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    expect_stalls(L_MUL, "mul_stall");
    check("mul_rs_data", rs_data, D_MUL);
    step();
    drain();
    check("mul_count", stall_count, C_MUL);

    // Write to $0 never matches
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'b00);
    step();
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    expect_stalls(0, "zero_stall");
    check("zero_rs_data", rs_data, RF_RS);
    step();
    drain();

    // Two writers of $7: youngest wins
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b00);
    step();
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'b00);
    step();
    stage_data = {32'h3333_0003, 32'h0000_000B, 32'h0000_000A};
    instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    expect_stalls(L_YNG, "young_stall");
    check("young_rs_data", rs_data, D_YNG);
    step();
    drain();
    check("young_count", stall_count, C_END);

    // Unused source never stalls
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'b01);
    step();
    instr(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 2'b00);
    expect_stalls(0, "unused_stall");
    check("unused_rt_data", rt_data, RF_RT);
    step();
    drain();
    check("unused_count", stall_count, C_END);

    // Hold during a load-use stall, then reset mid-stall
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'b01);
    step();
    instr(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'b00);
    pipe_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("hold_stall", {31'd0, stall}, 32'd1);
      check("hold_count", stall_count, C_END);
      step();
    end
    pipe_hold = 1'b0;
    #3;
    check("hold_release_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_count", stall_count, 32'd0);
    check("midreset_rt", rt_data, RF_RT);
    step();
    step();
    rst_n = 1'b1;
    step();
    #3;
    check("post_reset_stall", {31'd0, stall}, 32'd0);
    step();
    drain();
    check("post_reset_count", stall_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-resolution unit for the ID stage. It replaces the fixed EX/MEM forwarding and load-use stall logic with a shift-register scoreboard of in-flight destination registers, spanning a configurable number of downstream stages. Each entry records which stage its result becomes valid in, so multi-cycle results (loads, multiplies) stall their dependents for exactly the required number of cycles. It sits between the register file read ports and the decode operand muxes.

## Interface
- NUM_STAGES, 3, downstream stages tracked (slot 1 = EX … slot NUM_STAGES); ≥2
- DATA_W, 32, operand width
- LOAD_READY, 2, first slot index at which a load result is forwardable; 1..NUM_STAGES
- MUL_READY, 3, first slot index at which a MUL result is forwardable; 1..NUM_STAGES
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs_addr, id_rt_addr  in  5  source register addresses
- id_rs_used, id_rt_used  in  1  source is actually read
- id_we  in  1  instruction writes a register
- id_waddr  in  5  destination register
- id_class  in  2  result class: 00 ALU (ready slot 1), 01 load (LOAD_READY), 10 MUL (MUL_READY), 11 no result
- pipe_hold  in  1  whole pipeline frozen (e.g. memory wait)
- stage_data  in  NUM_STAGES*DATA_W  result value currently held in slot k, at bits [k*DATA_W-1 -: DATA_W]
- rs_data_in, rt_data_in  in  DATA_W  register file read data
- rs_data, rt_data  out  DATA_W  resolved operands
- stall  out  1  hold ID/IF, insert bubble into slot 1
- stall_count  out  32  cycles lost to hazard stalls

## Operation
- Slot k holds {valid, waddr, ready}; ready is 1 for ALU, LOAD_READY for loads, MUL_READY for MUL.
- Issue = id_valid & ~stall & ~pipe_hold. Only issued instructions with id_we=1, id_waddr≠0 and id_class≠11 create valid entries. Everything else enters as a bubble.
- Matching per source: scan slots 1..NUM_STAGES for valid entries with waddr == source address. The lowest-indexed (youngest) match wins. Source address 0 never matches.
- Winning slot k with k ≥ ready: forward stage_data slot k.
- Winning slot k with k < ready: hazard. If the source's *_used is set, that source raises stall.
- No match: pass rs_data_in / rt_data_in. The register file is write-through for the retiring stage.
- stall = id_valid & (rs hazard | rt hazard). Operand outputs are computed even when stall is asserted.
- stall_count increments by 1 on each clk edge with stall & ~pipe_hold. It wraps at 2^32.

## Timing
- Forwarding and stall are combinational from the inputs and the current slots; there is zero added latency.
- Shift on each edge with ~pipe_hold: slot k+1 ← slot k, slot 1 ← issued entry or bubble. The content of slot NUM_STAGES is discarded.
- pipe_hold=1: all slots and stall_count hold.
- A dependent of a load stalls LOAD_READY−d cycles, where d is its issue distance (1 = back-to-back). A dependent of a MUL stalls MUL_READY−d cycles.
- Simultaneous rs and rt hazards produce a single stall, which lasts until both resolve.
- Reset (asynchronous, any cycle, including mid-stall): all slots invalid, stall_count=0.
  - During reset, stall=0, rs_data=rs_data_in and rt_data=rt_data_in.
  - The first edge after rst_n rises behaves as a normal shift.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described.
- HAZARD_FWD_EN undefined: every match is a hazard regardless of ready. Dependents stall until the producer leaves slot NUM_STAGES, and rs_data/rt_data always equal the register file data. This is the reference mode for debugging forwarding.

## Test plan
All scenarios use the defaults (NUM_STAGES=3, LOAD_READY=2, MUL_READY=3) with HAZARD_FWD_EN defined unless noted.
- ALU to back-to-back reader: issue ADD → $3; next cycle rs=$3 with slot1 data 0x00001234 → stall=0, rs_data=0x00001234.
- Load-use: LW → $5, then a reader with rt=$5, rt_used=1 → stall=1 for exactly 1 cycle, then rt_data = slot-2 data, stall_count=1.
- MUL dependency: MUL → $8, then a reader of $8 → stall for 2 cycles, then forward from slot 3. Same sequence with HAZARD_FWD_EN undefined → 3 stall cycles, rs_data=rs_data_in.
- Zero and youngest rules:
  - A write to $0 followed by a read of $0 → no stall, rs_data=rs_data_in.
  - Writes to $7 in slot 1 (0xA) and slot 2 (0xB) → rs_data=0xA.
- Unused source: LW → $9, then an immediate op with rt=$9, rt_used=0 → stall=0.
- Hold and reset: pipe_hold=1 for 4 cycles during a load-use stall → stall stays 1 and stall_count is frozen. Asserting rst_n=0 mid-stall → stall=0 immediately and stall_count=0.
